rx_frame_decoder: RTL and testbench

Parses the byte stream produced by the receive-side UDP stage (Rx FIFO data/enable, protocol-1 host-to-radio frames) into control words and 16-bit sample words. Sits directly downstream of the ethernet block's `Rx_fifo_data_o`/`Rx_enable_o` outputs, in the `PHY_data_clock` (rx_clk) domain, and feeds the control-register file and the TX I/Q / audio paths.

---
 rtl/rx_frame_decoder.sv | 147 ++++++++++++++
 tb/tb_rx_frame_decoder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_decoder.sv
// Protocol-1 host-to-radio frame parser: 3 sync bytes, 5 control bytes, then
// SAMPLES_PER_FRAME groups of L/R/I/Q words. Optional stats via RX_FRAME_STATS_EN.
module rx_frame_decoder #(
  parameter int         SAMPLES_PER_FRAME = 63,
  parameter logic [7:0] SYNC_BYTE         = 8'h7F
) (
  input  logic        rx_clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [6:0]  ctrl_addr,
  output logic        mox,
  output logic [31:0] ctrl_data,
  output logic        ctrl_valid,
  output logic [15:0] audio_l,
  output logic [15:0] audio_r,
  output logic [15:0] tx_i,
  output logic [15:0] tx_q,
  output logic        sample_valid,
  output logic        locked,
  output logic [15:0] frame_count,
  output logic [15:0] sync_err_count
);

  localparam int PAYLOAD_BYTES = SAMPLES_PER_FRAME * 8;
  localparam int IDX_W         = $clog2(PAYLOAD_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

  localparam logic [2:0] ST_HUNT0   = 3'd0;
  localparam logic [2:0] ST_HUNT1   = 3'd1;
  localparam logic [2:0] ST_HUNT2   = 3'd2;
  localparam logic [2:0] ST_HDR     = 3'd3;
  localparam logic [2:0] ST_PAYLOAD = 3'd4;

  logic [2:0]       state;
  logic [2:0]       hdr_idx;
  logic [IDX_W-1:0] byte_idx;
  logic [31:0]      hdr_shift;
  logic [55:0]      smp_shift;

  logic is_sync;
  logic in_hunt;
  logic lock_lost;
  logic frame_done;

  assign is_sync    = (rx_data == SYNC_BYTE);
  assign in_hunt    = (state == ST_HUNT0) || (state == ST_HUNT1) || (state == ST_HUNT2);
  assign lock_lost  = rx_valid && in_hunt && !is_sync && locked;
  assign frame_done = rx_valid && (state == ST_PAYLOAD) && (byte_idx == LAST_IDX);

  // Header holds C0..C3 in hdr_shift and commits all control outputs on C4;
  // samples likewise accumulate 7 bytes and commit on Q_lo.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_HUNT0;
      hdr_idx      <= '0;
      byte_idx     <= '0;
      hdr_shift    <= '0;
      smp_shift    <= '0;
      ctrl_addr    <= '0;
      mox          <= 1'b0;
      ctrl_data    <= '0;
      ctrl_valid   <= 1'b0;
      audio_l      <= '0;
      audio_r      <= '0;
      tx_i         <= '0;
      tx_q         <= '0;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
    end else begin
      ctrl_valid   <= 1'b0;
      sample_valid <= 1'b0;

      if (rx_valid) begin
        case (state)
          ST_HUNT0: state <= is_sync ? ST_HUNT1 : ST_HUNT0;
          ST_HUNT1: state <= is_sync ? ST_HUNT2 : ST_HUNT0;
          ST_HUNT2: begin
            state   <= is_sync ? ST_HDR : ST_HUNT0;
            hdr_idx <= '0;
          end
          ST_HDR: begin
            hdr_shift <= {hdr_shift[23:0], rx_data};
            if (hdr_idx == 3'd4) begin
              ctrl_addr  <= hdr_shift[31:25];
              mox        <= hdr_shift[24];
              ctrl_data  <= {hdr_shift[23:0], rx_data};
              ctrl_valid <= 1'b1;
              byte_idx   <= '0;
              state      <= ST_PAYLOAD;
            end else begin
              hdr_idx <= hdr_idx + 3'd1;
            end
          end
          ST_PAYLOAD: begin
            if (byte_idx[2:0] == 3'd7) begin
              {audio_l, audio_r, tx_i, tx_q} <= {smp_shift, rx_data};
              sample_valid <= 1'b1;
            end else begin
              smp_shift <= {smp_shift[47:0], rx_data};
            end
            if (byte_idx == LAST_IDX) begin
              byte_idx <= '0;
              state    <= ST_HUNT0;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
          default: state <= ST_HUNT0;
        endcase
      end

      if (lock_lost) begin
        locked <= 1'b0;
      end else if (frame_done) begin
        locked <= 1'b1;
      end
    end
  end

`ifdef RX_FRAME_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] err_cnt_q;

  // Frame count wraps; lock-loss count saturates so it never reads as healthy.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (frame_done) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (lock_lost && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign frame_count    = frame_cnt_q;
  assign sync_err_count = err_cnt_q;
`else
  assign frame_count    = 16'h0000;
  assign sync_err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_rx_frame_decoder.sv
// Directed bench for rx_frame_decoder: table of frame vectors plus hand-written
// sequences for garbage, lock loss and mid-frame reset.
module tb_rx_frame_decoder;

  localparam int SPF         = 63;
  localparam int FRAME_BYTES = 8 + 8 * SPF;
`ifdef RX_FRAME_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        rx_clk = 1'b0;
  logic        rst_n  = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [6:0]  ctrl_addr;
  logic        mox;
  logic [31:0] ctrl_data;
  logic        ctrl_valid;
  logic [15:0] audio_l, audio_r, tx_i, tx_q;
  logic        sample_valid;
  logic        locked;
  logic [15:0] frame_count;
  logic [15:0] sync_err_count;

  rx_frame_decoder #(.SAMPLES_PER_FRAME(SPF), .SYNC_BYTE(8'h7F)) dut (
    .rx_clk(rx_clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .ctrl_addr(ctrl_addr), .mox(mox), .ctrl_data(ctrl_data), .ctrl_valid(ctrl_valid),
    .audio_l(audio_l), .audio_r(audio_r), .tx_i(tx_i), .tx_q(tx_q),
    .sample_valid(sample_valid), .locked(locked),
    .frame_count(frame_count), .sync_err_count(sync_err_count)
  );

  always #5 rx_clk = ~rx_clk;

  int total = 0;
  int bad = 0;
  int ctrl_cnt = 0;
  int sample_cnt = 0;
  logic [63:0] exp_smp = '0;
  logic prev_valid = 1'b0;
  logic prev_ctrl = 1'b0;
  logic prev_smp = 1'b0;

  typedef struct {
    logic [39:0] hdr;
    logic [63:0] smp;
    bit          gap;
    logic [6:0]  exp_addr;
    logic        exp_mox;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[4];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] exp_stat(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  always @(posedge rx_clk) prev_valid <= rx_valid;

  // Strobe monitor: checks sample payload, strobe width and that strobes follow a valid byte.
  always @(negedge rx_clk) begin
    if (!rst_n) begin
      prev_ctrl = 1'b0;
      prev_smp  = 1'b0;
    end else begin
      if (ctrl_valid) begin
        ctrl_cnt++;
        checkOutput("ctrl_after_valid_byte", {31'd0, prev_valid}, 32'd1);
        checkOutput("ctrl_valid_width", {31'd0, prev_ctrl}, 32'd0);
      end
      if (sample_valid) begin
        sample_cnt++;
        checkOutput("audio_l", {16'd0, audio_l}, {16'd0, exp_smp[63:48]});
        checkOutput("audio_r", {16'd0, audio_r}, {16'd0, exp_smp[47:32]});
        checkOutput("tx_i", {16'd0, tx_i}, {16'd0, exp_smp[31:16]});
        checkOutput("tx_q", {16'd0, tx_q}, {16'd0, exp_smp[15:0]});
        checkOutput("sample_after_valid_byte", {31'd0, prev_valid}, 32'd1);
        checkOutput("sample_valid_width", {31'd0, prev_smp}, 32'd0);
      end
      prev_ctrl = ctrl_valid;
      prev_smp  = sample_valid;
    end
  end

  task automatic applyStimulus(input logic [7:0] b, input bit gap);
    @(negedge rx_clk);
    rx_data  = b;
    rx_valid = 1'b1;
    if (gap) begin
      @(negedge rx_clk);
      rx_valid = 1'b0;
      rx_data  = 8'h7F;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge rx_clk);
      rx_valid = 1'b0;
    end
  endtask

  function automatic logic [7:0] frame_byte(input int i, input logic [39:0] hdr,
                                            input logic [63:0] smp, input logic [7:0] sync2);
    int j;
    if (i < 3) return (i == 1) ? sync2 : 8'h7F;
    if (i < 8) return hdr[(7 - i) * 8 +: 8];
    j = (i - 8) % 8;
    return smp[(7 - j) * 8 +: 8];
  endfunction

  task automatic send_frame(input logic [39:0] hdr, input logic [63:0] smp, input bit gap,
                            input logic [7:0] sync2, input int first, input int last);
    for (int i = first; i < last; i++) applyStimulus(frame_byte(i, hdr, smp, sync2), gap);
  endtask

  task automatic do_reset();
    @(negedge rx_clk);
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    #3;
    rst_n      = 1'b1;
    ctrl_cnt   = 0;
    sample_cnt = 0;
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_ctrl_addr"}, {25'd0, ctrl_addr}, 32'd0);
    checkOutput({tag, "_mox"}, {31'd0, mox}, 32'd0);
    checkOutput({tag, "_ctrl_data"}, ctrl_data, 32'd0);
    checkOutput({tag, "_ctrl_valid"}, {31'd0, ctrl_valid}, 32'd0);
    checkOutput({tag, "_samples_lr"}, {audio_l, audio_r}, 32'd0);
    checkOutput({tag, "_samples_iq"}, {tx_i, tx_q}, 32'd0);
    checkOutput({tag, "_sample_valid"}, {31'd0, sample_valid}, 32'd0);
    checkOutput({tag, "_locked"}, {31'd0, locked}, 32'd0);
    checkOutput({tag, "_frame_count"}, {16'd0, frame_count}, 32'd0);
    checkOutput({tag, "_sync_err_count"}, {16'd0, sync_err_count}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{40'h13DEADBEEF, 64'h0102030405060708, 1'b0, 7'h09, 1'b1, 32'hDEADBEEF};
    vecs[1] = '{40'h13DEADBEEF, 64'h0102030405060708, 1'b1, 7'h09, 1'b1, 32'hDEADBEEF};
    vecs[2] = '{40'hFE01234567, 64'h8000FFFF00FF7F80, 1'b0, 7'h7F, 1'b0, 32'h01234567};
    vecs[3] = '{40'h0100000001, 64'hFFFE0001A5A55A5A, 1'b1, 7'h00, 1'b1, 32'h00000001};

    #2;
    check_all_zero("reset");
    do_reset();
    check_all_zero("post_reset");

    for (int v = 0; v < 4; v++) begin
      do_reset();
      exp_smp = vecs[v].smp;
      send_frame(vecs[v].hdr, vecs[v].smp, vecs[v].gap, 8'h7F, 0, FRAME_BYTES);
      idle(3);
      checkOutput("vec_ctrl_count", ctrl_cnt, 32'd1);
      checkOutput("vec_sample_count", sample_cnt, SPF);
      checkOutput("vec_ctrl_addr", {25'd0, ctrl_addr}, {25'd0, vecs[v].exp_addr});
      checkOutput("vec_mox", {31'd0, mox}, {31'd0, vecs[v].exp_mox});
      checkOutput("vec_ctrl_data", ctrl_data, vecs[v].exp_data);
      checkOutput("vec_locked", {31'd0, locked}, 32'd1);
      checkOutput("vec_frame_count", {16'd0, frame_count}, exp_stat(1));
      checkOutput("vec_sync_err_count", {16'd0, sync_err_count}, 32'd0);
    end

    // Partial sync match followed by a real frame.
    do_reset();
    exp_smp = vecs[0].smp;
    applyStimulus(8'h7F, 1'b0);
    applyStimulus(8'h7F, 1'b0);
    applyStimulus(8'h00, 1'b0);
    idle(2);
    checkOutput("garbage_no_ctrl", ctrl_cnt, 32'd0);
    checkOutput("garbage_locked", {31'd0, locked}, 32'd0);
    send_frame(vecs[0].hdr, vecs[0].smp, 1'b0, 8'h7F, 0, FRAME_BYTES);
    idle(3);
    checkOutput("garbage_ctrl_count", ctrl_cnt, 32'd1);
    checkOutput("garbage_ctrl_data", ctrl_data, 32'hDEADBEEF);
    checkOutput("garbage_sample_count", sample_cnt, SPF);
    checkOutput("garbage_sync_err_count", {16'd0, sync_err_count}, 32'd0);
    checkOutput("garbage_frame_count", {16'd0, frame_count}, exp_stat(1));

    // Lock loss on a corrupted second sync byte, then relock.
    do_reset();
    exp_smp = vecs[0].smp;
    send_frame(vecs[0].hdr, vecs[0].smp, 1'b0, 8'h7F, 0, FRAME_BYTES);
    send_frame(vecs[0].hdr, vecs[0].smp, 1'b0, 8'h7F, 0, FRAME_BYTES);
    idle(2);
    checkOutput("lock_two_frames", {31'd0, locked}, 32'd1);
    checkOutput("lock_frame_count2", {16'd0, frame_count}, exp_stat(2));
    send_frame(vecs[0].hdr, vecs[0].smp, 1'b0, 8'h7E, 0, 2);
    idle(2);
    checkOutput("lock_dropped", {31'd0, locked}, 32'd0);
    checkOutput("lock_err_count", {16'd0, sync_err_count}, exp_stat(1));
    send_frame(vecs[0].hdr, vecs[0].smp, 1'b0, 8'h7E, 2, FRAME_BYTES);
    idle(2);
    checkOutput("lock_bad_no_ctrl", ctrl_cnt, 32'd2);
    checkOutput("lock_bad_no_samples", sample_cnt, 2 * SPF);
    checkOutput("lock_err_count_once", {16'd0, sync_err_count}, exp_stat(1));
    checkOutput("lock_still_unlocked", {31'd0, locked}, 32'd0);
    send_frame(vecs[0].hdr, vecs[0].smp, 1'b0, 8'h7F, 0, FRAME_BYTES);
    idle(2);
    checkOutput("relock", {31'd0, locked}, 32'd1);
    checkOutput("relock_frame_count", {16'd0, frame_count}, exp_stat(3));
    checkOutput("relock_err_count", {16'd0, sync_err_count}, exp_stat(1));
    checkOutput("relock_ctrl_count", ctrl_cnt, 32'd3);

    // Asynchronous reset in the middle of a frame.
    do_reset();
    exp_smp = vecs[0].smp;
    send_frame(vecs[0].hdr, vecs[0].smp, 1'b0, 8'h7F, 0, FRAME_BYTES);
    send_frame(vecs[0].hdr, vecs[0].smp, 1'b0, 8'h7F, 0, 200);
    @(posedge rx_clk);
    #2;
    checkOutput("midreset_pre_locked", {31'd0, locked}, 32'd1);
    checkOutput("midreset_pre_samples", {tx_i, tx_q}, 32'h05060708);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    rx_valid = 1'b0;
    @(negedge rx_clk);
    #3;
    rst_n      = 1'b1;
    ctrl_cnt   = 0;
    sample_cnt = 0;
    exp_smp    = vecs[2].smp;
    send_frame(vecs[2].hdr, vecs[2].smp, 1'b0, 8'h7F, 0, FRAME_BYTES);
    idle(3);
    checkOutput("after_reset_ctrl_count", ctrl_cnt, 32'd1);
    checkOutput("after_reset_ctrl_data", ctrl_data, 32'h01234567);
    checkOutput("after_reset_ctrl_addr", {25'd0, ctrl_addr}, 32'h7F);
    checkOutput("after_reset_sample_count", sample_cnt, SPF);
    checkOutput("after_reset_locked", {31'd0, locked}, 32'd1);
    checkOutput("after_reset_frame_count", {16'd0, frame_count}, exp_stat(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
